hazard_stall_ctrl: RTL

- Consumer-side control for the ID/EX pipeline register. Watches the fields the ID/EX register presents to EX, plus the instruction currently in IF/ID.
- Detects load-use hazards and generates the PC/IF-ID hold and ID/EX bubble controls.
- Arbitrates stalls against branch/jump-register redirects from later stages, and keeps saturating stall/flush statistics for bring-up.

---
 rtl/hazard_stall_ctrl_pkg.sv | 27 ++
 rtl/hazard_stall_ctrl_sat.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the ID/EX load-use hazard / stall controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Pipeline control tuple driven toward PC, IF/ID and ID/EX.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  // Free-running pipeline: both loads enabled, no bubble, no flush.
  localparam ctrl_t CTRL_RUN   = ctrl_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  // Hold PC and IF/ID, inject a bubble into ID/EX.
  localparam ctrl_t CTRL_HOLD  = ctrl_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  // Redirect: keep fetching from the new target, squash IF/ID and ID/EX.
  localparam ctrl_t CTRL_FLUSH = ctrl_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_stall_ctrl_sat.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear wins; otherwise count up and stick at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n)
      r_count <= '0;
    else if (i_inc && (r_count != {W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection, stall/bubble generation and redirect arbitration
// for the ID/EX pipeline register, with saturating bring-up statistics.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_DstReg,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             Branch_taken,
  input  logic             JReg_taken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Stalled,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  // Bubbles still owed after the first one, loaded on entry to STALL.
  localparam logic [3:0] STALL_EXTRA = 4'(LOAD_USE_STALL - 1);

  state_e     r_state, w_next_state;
  logic [3:0] r_remaining, w_next_remaining;
  ctrl_t      w_ctrl;
  logic       w_hazard, w_redirect;
  logic       w_stall_inc, w_flush_inc;

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign w_hazard = IDEX_MemRead && (IDEX_DstReg != REG_ZERO) &&
                    ((IDEX_DstReg == IFID_Rs) ||
                     (IFID_UsesRt && (IDEX_DstReg == IFID_Rt)));
  assign w_redirect = Branch_taken | JReg_taken;

  // State and remaining-bubble counter; reset aborts any stall in progress.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= ST_RUN;
      r_remaining <= 4'd0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
    end
  end

  // Next state and same-cycle controls; a redirect always beats a stall
  // because the stalled instruction is being squashed anyway.
  always_comb begin
    w_ctrl           = CTRL_RUN;
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    w_stall_inc      = 1'b0;
    w_flush_inc      = 1'b0;
    if (Rst) begin
      unique case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            w_ctrl      = CTRL_FLUSH;
            w_flush_inc = 1'b1;
          end else if (w_hazard) begin
            w_ctrl      = CTRL_HOLD;
            w_stall_inc = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              w_next_state     = ST_STALL;
              w_next_remaining = STALL_EXTRA;
            end
          end
        end
        ST_STALL: begin
          if (w_redirect) begin
            w_ctrl           = CTRL_FLUSH;
            w_flush_inc      = 1'b1;
            w_next_state     = ST_RUN;
            w_next_remaining = 4'd0;
          end else begin
            w_ctrl           = CTRL_HOLD;
            w_stall_inc      = 1'b1;
            w_next_remaining = r_remaining - 4'd1;
            if (r_remaining == 4'd1)
              w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state     = ST_RUN;
          w_next_remaining = 4'd0;
        end
      endcase
    end
  end

  assign PCWrite     = w_ctrl.pc_write;
  assign IFIDWrite   = w_ctrl.ifid_write;
  assign IDEX_Bubble = w_ctrl.idex_bubble;
  assign IFID_Flush  = w_ctrl.ifid_flush;
  assign IDEX_Flush  = w_ctrl.idex_flush;
  assign Stalled     = Rst && (r_state == ST_STALL);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (Clk),
    .i_clr_n (Rst),
    .i_inc   (w_stall_inc),
    .o_count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (Clk),
    .i_clr_n (Rst),
    .i_inc   (w_flush_inc),
    .o_count (FlushCount)
  );

endmodule
